// File: rtl/vc_evict_txdat.sv
// Evict write-back sender: buffers evicted line beats in a small FIFO, forwards them downstream
// and pulses adp_done with the MSHR index once the last beat of a line is handed off.
module vc_evict_txdat #(
   parameter int unsigned DATA_W     = 256,
   parameter int unsigned BEATS      = 4,
   parameter int unsigned IDX_W      = 5,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              evict_data_vld,
   input  logic [DATA_W-1:0] evict_data,
   input  logic [IDX_W-1:0]  evict_data_idx,
   output logic              evict_data_rdy,
   output logic              downstream_txdat_vld,
   output logic [DATA_W-1:0] downstream_txdat_data,
   output logic [IDX_W-1:0]  downstream_txdat_idx,
   output logic              downstream_txdat_last,
   input  logic              downstream_txdat_rdy,
   output logic              adp_done,
   output logic [IDX_W-1:0]  adp_done_idx
);

   localparam int unsigned CntW  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned PtrFW = PtrW + 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(BEATS - 1);

   typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

   state_e              state_q, state_d;
   logic                rdy_en_q;
   logic [CntW-1:0]     in_cnt_q, in_cnt_d;
   logic [IDX_W-1:0]    cur_idx_q, cur_idx_d;
   logic [PtrFW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PtrFW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [IDX_W-1:0]    done_idx_q, done_idx_d;

   logic [DATA_W-1:0]   mem_data_q [FIFO_DEPTH];
   logic [IDX_W-1:0]    mem_idx_q  [FIFO_DEPTH];
   logic                mem_last_q [FIFO_DEPTH];

   logic                fifo_empty;
   logic                fifo_full;
   logic                idx_ok;
   logic                push;
   logic                pop;
   logic [DATA_W-1:0]   head_data;
   logic [IDX_W-1:0]    head_idx;
   logic                head_last;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                       (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

   // Mid-line beats of another entry are held off so lines never interleave.
   assign idx_ok         = (in_cnt_q == '0) || (evict_data_idx == cur_idx_q);
   assign evict_data_rdy = rdy_en_q && !fifo_full && idx_ok;
   assign push           = evict_data_vld && evict_data_rdy;

   assign head_data = mem_data_q[rd_ptr_q[PtrW-1:0]];
   assign head_idx  = mem_idx_q[rd_ptr_q[PtrW-1:0]];
   assign head_last = mem_last_q[rd_ptr_q[PtrW-1:0]];

   assign downstream_txdat_vld  = !fifo_empty;
   assign downstream_txdat_data = fifo_empty ? '0 : head_data;
   assign downstream_txdat_idx  = fifo_empty ? '0 : head_idx;
   assign downstream_txdat_last = fifo_empty ? 1'b0 : head_last;
   assign pop                   = downstream_txdat_vld && downstream_txdat_rdy;

   assign adp_done     = (state_q == StDone);
   assign adp_done_idx = done_idx_q;

   always_comb begin
      in_cnt_d  = in_cnt_q;
      cur_idx_d = cur_idx_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      if (push) begin
         in_cnt_d = in_cnt_q + CntW'(1);
         wr_ptr_d = wr_ptr_q + PtrFW'(1);
         if (in_cnt_q == '0) begin
            cur_idx_d = evict_data_idx;
         end
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrFW'(1);
      end
   end

   always_comb begin
      state_d    = state_q;
      done_idx_d = done_idx_q;
      if (pop && head_last) begin
         done_idx_d = head_idx;
      end
      unique case (state_q)
         StIdle: begin
            if (pop) begin
               state_d = head_last ? StDone : StSend;
            end
         end
         StSend: begin
            if (pop && head_last) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (pop) begin
               state_d = head_last ? StDone : StSend;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_en_q   <= 1'b0;
         in_cnt_q   <= '0;
         cur_idx_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         state_q    <= StIdle;
         done_idx_q <= '0;
      end else begin
         rdy_en_q   <= 1'b1;
         in_cnt_q   <= in_cnt_d;
         cur_idx_q  <= cur_idx_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         state_q    <= state_d;
         done_idx_q <= done_idx_d;
      end
   end

   // Storage needs no reset: the pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_data_q[wr_ptr_q[PtrW-1:0]] <= evict_data;
         mem_idx_q[wr_ptr_q[PtrW-1:0]]  <= evict_data_idx;
         mem_last_q[wr_ptr_q[PtrW-1:0]] <= (in_cnt_q == LastCnt);
      end
   end

endmodule

// File: tb/tb_vc_evict_txdat.sv
// Self-checking bench for vc_evict_txdat: a queue-based reference model plus per-scenario checks.
module tb_vc_evict_txdat;

   localparam int unsigned DW = 256;
   localparam int unsigned BT = 4;
   localparam int unsigned IW = 5;
   localparam int unsigned FD = 4;

   typedef struct {
      logic [DW-1:0] data;
      logic [IW-1:0] idx;
      logic          last;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          evict_data_vld = 1'b0;
   logic [DW-1:0] evict_data = '0;
   logic [IW-1:0] evict_data_idx = '0;
   logic          evict_data_rdy;
   logic          downstream_txdat_vld;
   logic [DW-1:0] downstream_txdat_data;
   logic [IW-1:0] downstream_txdat_idx;
   logic          downstream_txdat_last;
   logic          downstream_txdat_rdy = 1'b0;
   logic          adp_done;
   logic [IW-1:0] adp_done_idx;

   vc_evict_txdat #(
      .DATA_W     (DW),
      .BEATS      (BT),
      .IDX_W      (IW),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .evict_data_vld        (evict_data_vld),
      .evict_data            (evict_data),
      .evict_data_idx        (evict_data_idx),
      .evict_data_rdy        (evict_data_rdy),
      .downstream_txdat_vld  (downstream_txdat_vld),
      .downstream_txdat_data (downstream_txdat_data),
      .downstream_txdat_idx  (downstream_txdat_idx),
      .downstream_txdat_last (downstream_txdat_last),
      .downstream_txdat_rdy  (downstream_txdat_rdy),
      .adp_done              (adp_done),
      .adp_done_idx          (adp_done_idx)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   // Reference model state
   beat_t         mq[$];
   int            m_pos = 0;
   logic [IW-1:0] m_cur = '0;
   logic          m_en = 1'b0;
   logic          m_done = 1'b0;
   logic [IW-1:0] m_done_idx = '0;

   // Observed and expected values of the last cycle
   logic          obs_rdy, obs_vld, obs_last, obs_done, obs_dr;
   logic [DW-1:0] obs_data;
   logic [IW-1:0] obs_idx, obs_done_idx;
   logic          exp_rdy, exp_vld, exp_done;
   logic [IW-1:0] exp_done_idx;
   beat_t         exp_head;

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] r;
      for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_pos      = 0;
      m_cur      = '0;
      m_en       = 1'b0;
      m_done     = 1'b0;
      m_done_idx = '0;
   endtask

   task automatic release_reset();
      evict_data_vld       = 1'b0;
      downstream_txdat_rdy = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      m_en = 1'b1;
   endtask

   // Drives one cycle, snapshots DUT and model outputs mid-cycle, then advances the model.
   task automatic run_cycle(input logic v, input logic [DW-1:0] d, input logic [IW-1:0] i,
                            input logic dr, output logic acc);
      beat_t b;
      logic  hs;
      evict_data_vld       = v;
      evict_data           = d;
      evict_data_idx       = i;
      downstream_txdat_rdy = dr;
      @(negedge clk);
      obs_rdy      = evict_data_rdy;
      obs_vld      = downstream_txdat_vld;
      obs_data     = downstream_txdat_data;
      obs_idx      = downstream_txdat_idx;
      obs_last     = downstream_txdat_last;
      obs_done     = adp_done;
      obs_done_idx = adp_done_idx;
      obs_dr       = dr;
      exp_rdy      = m_en && (mq.size() < FD) && (m_pos == 0 || i == m_cur);
      exp_vld      = (mq.size() > 0);
      if (exp_vld) begin
         exp_head = mq[0];
      end else begin
         exp_head.data = '0;
         exp_head.idx  = '0;
         exp_head.last = 1'b0;
      end
      exp_done     = m_done;
      exp_done_idx = m_done_idx;
      acc = v && exp_rdy;
      hs  = exp_vld && dr;
      @(posedge clk);
      m_done = 1'b0;
      if (hs) begin
         b = mq.pop_front();
         if (b.last) begin
            m_done     = 1'b1;
            m_done_idx = b.idx;
         end
      end
      if (acc) begin
         b.data = d;
         b.idx  = i;
         b.last = (m_pos == BT - 1);
         if (m_pos == 0) m_cur = i;
         m_pos = (m_pos + 1) % BT;
         mq.push_back(b);
      end
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (evict_data_rdy !== 1'b0) begin
         n_fail++; $display("FAIL reset_rdy: got %b want 0", evict_data_rdy);
      end
      n_cmp++;
      if (downstream_txdat_vld !== 1'b0 || downstream_txdat_last !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_vld_last: got %b/%b want 0/0", downstream_txdat_vld,
                  downstream_txdat_last);
      end
      n_cmp++;
      if (downstream_txdat_data !== '0 || downstream_txdat_idx !== '0) begin
         n_fail++;
         $display("FAIL reset_payload: got %h/%0d want 0/0", downstream_txdat_data,
                  downstream_txdat_idx);
      end
      n_cmp++;
      if (adp_done !== 1'b0 || adp_done_idx !== '0) begin
         n_fail++; $display("FAIL reset_done: got %b/%0d want 0/0", adp_done, adp_done_idx);
      end
      release_reset();
      n_cmp++;
      if (evict_data_rdy !== 1'b1) begin
         n_fail++; $display("FAIL reset_release_rdy: got %b want 1", evict_data_rdy);
      end
   endtask

   task automatic test_basic();
      logic          acc, want_v;
      logic [DW-1:0] want_d;
      for (int c = 0; c < 8; c++) begin
         want_d = DW'(32'hA0 + c);
         run_cycle(c < 4, want_d, 5'd3, 1'b1, acc);
         n_cmp++;
         if (obs_rdy !== exp_rdy || obs_vld !== exp_vld || obs_done !== exp_done ||
             (exp_vld && (obs_data !== exp_head.data || obs_idx !== exp_head.idx ||
                          obs_last !== exp_head.last)) ||
             (exp_done && obs_done_idx !== exp_done_idx)) begin
            n_fail++;
            $display("FAIL basic_model c=%0d: got rdy=%b vld=%b last=%b done=%b, want %b %b %b %b",
                     c, obs_rdy, obs_vld, obs_last, obs_done, exp_rdy, exp_vld, exp_head.last,
                     exp_done);
         end
         want_v = (c >= 1 && c <= 4);
         want_d = DW'(32'hA0 + c - 1);
         n_cmp++;
         if (obs_vld !== want_v || (want_v && (obs_data !== want_d || obs_idx !== 5'd3 ||
                                               obs_last !== (c == 4)))) begin
            n_fail++;
            $display("FAIL basic_beat c=%0d: got vld=%b data=%h last=%b, want vld=%b data=%h",
                     c, obs_vld, obs_data, obs_last, want_v, want_d);
         end
         n_cmp++;
         if (obs_done !== (c == 5) || (c == 5 && obs_done_idx !== 5'd3)) begin
            n_fail++;
            $display("FAIL basic_done c=%0d: got %b idx %0d, want %b idx 3", c, obs_done,
                     obs_done_idx, (c == 5));
         end
      end
   endtask

   task automatic test_backpressure();
      beat_t stim[$];
      beat_t b;
      logic  acc, v;
      int    early_acc = 0;
      int    dones = 0;
      for (int k = 0; k < 8; k++) begin
         b.data = rand_data();
         b.idx  = (k < 4) ? 5'd6 : 5'd9;
         b.last = 1'b0;
         stim.push_back(b);
      end
      for (int c = 0; c < 30; c++) begin
         v = (stim.size() > 0);
         b = v ? stim[0] : b;
         run_cycle(v, b.data, b.idx, c >= 6, acc);
         if (acc) void'(stim.pop_front());
         if (c < 6 && v && obs_rdy) early_acc++;
         if (obs_done) dones++;
         n_cmp++;
         if (obs_rdy !== exp_rdy || obs_vld !== exp_vld || obs_done !== exp_done ||
             (exp_vld && (obs_data !== exp_head.data || obs_idx !== exp_head.idx ||
                          obs_last !== exp_head.last)) ||
             (exp_done && obs_done_idx !== exp_done_idx)) begin
            n_fail++;
            $display("FAIL bp_model c=%0d: got rdy=%b vld=%b idx=%0d done=%b, want %b %b %0d %b",
                     c, obs_rdy, obs_vld, obs_idx, obs_done, exp_rdy, exp_vld, exp_head.idx,
                     exp_done);
         end
         if (c == 5) begin
            n_cmp++;
            if (obs_rdy !== 1'b0) begin
               n_fail++; $display("FAIL bp_full_rdy: got %b want 0", obs_rdy);
            end
         end
      end
      n_cmp++;
      if (early_acc != 4) begin
         n_fail++; $display("FAIL bp_accepts: got %0d want 4", early_acc);
      end
      n_cmp++;
      if (dones != 2 || obs_vld !== 1'b0 || stim.size() != 0) begin
         n_fail++;
         $display("FAIL bp_drain: got dones=%0d vld=%b left=%0d want 2 0 0", dones, obs_vld,
                  stim.size());
      end
   endtask

   task automatic test_interleave();
      int   seq_idx[11];
      bit   seq_rdy[11];
      logic acc;
      int   c;
      seq_idx = '{1, 2, 2, 2, 1, 1, 1, 2, 2, 2, 2};
      seq_rdy = '{1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
      for (c = 0; c < 16; c++) begin
         if (c < 11) run_cycle(1'b1, rand_data(), IW'(seq_idx[c]), 1'b1, acc);
         else        run_cycle(1'b0, '0, '0, 1'b1, acc);
         n_cmp++;
         if (obs_rdy !== exp_rdy || obs_vld !== exp_vld || obs_done !== exp_done ||
             (exp_vld && (obs_data !== exp_head.data || obs_idx !== exp_head.idx ||
                          obs_last !== exp_head.last)) ||
             (exp_done && obs_done_idx !== exp_done_idx)) begin
            n_fail++;
            $display("FAIL il_model c=%0d: got rdy=%b vld=%b idx=%0d done=%b, want %b %b %0d %b",
                     c, obs_rdy, obs_vld, obs_idx, obs_done, exp_rdy, exp_vld, exp_head.idx,
                     exp_done);
         end
         if (c < 11) begin
            n_cmp++;
            if (obs_rdy !== seq_rdy[c]) begin
               n_fail++;
               $display("FAIL il_rdy c=%0d idx=%0d: got %b want %b", c, seq_idx[c], obs_rdy,
                        seq_rdy[c]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic acc;
      int   hs_n = 0, first_hs = -1, last_hs = -1;
      int   last_at[$];
      int   done_c[$];
      logic [IW-1:0] done_i[$];
      for (int c = 0; c < 14; c++) begin
         run_cycle(c < 8, rand_data(), (c < 4) ? 5'd4 : 5'd5, 1'b1, acc);
         n_cmp++;
         if (obs_rdy !== exp_rdy || obs_vld !== exp_vld || obs_done !== exp_done ||
             (exp_vld && (obs_data !== exp_head.data || obs_idx !== exp_head.idx ||
                          obs_last !== exp_head.last)) ||
             (exp_done && obs_done_idx !== exp_done_idx)) begin
            n_fail++;
            $display("FAIL b2b_model c=%0d: got rdy=%b vld=%b idx=%0d done=%b, want %b %b %0d %b",
                     c, obs_rdy, obs_vld, obs_idx, obs_done, exp_rdy, exp_vld, exp_head.idx,
                     exp_done);
         end
         if (obs_vld === 1'b1) begin
            hs_n++;
            if (first_hs < 0) first_hs = c;
            last_hs = c;
            if (obs_last === 1'b1) last_at.push_back(hs_n);
         end
         if (obs_done === 1'b1) begin
            done_c.push_back(c);
            done_i.push_back(obs_done_idx);
         end
      end
      n_cmp++;
      if (hs_n != 8 || last_hs - first_hs != 7) begin
         n_fail++;
         $display("FAIL b2b_beats: got %0d beats over %0d cycles want 8 over 8", hs_n,
                  last_hs - first_hs + 1);
      end
      n_cmp++;
      if (last_at.size() != 2 || last_at[0] != 4 || last_at[1] != 8) begin
         n_fail++; $display("FAIL b2b_last: got %0d last flags want beats 4 and 8", last_at.size());
      end
      n_cmp++;
      if (done_c.size() != 2 || done_c[1] - done_c[0] != 4 || done_i[0] !== 5'd4 ||
          done_i[1] !== 5'd5) begin
         n_fail++; $display("FAIL b2b_done: got %0d pulses want idx 4 then 5, 4 apart", done_c.size());
      end
   endtask

   task automatic test_stall();
      beat_t stim[$];
      beat_t b;
      logic  acc, v, dr;
      logic  prev_vld = 1'b0, prev_dr = 1'b0, prev_last_hs = 1'b0;
      logic [DW-1:0] prev_data = '0;
      logic [IW-1:0] prev_idx = '0;
      int    lines = 0;
      for (int k = 0; k < 2 * BT; k++) begin
         b.data = rand_data();
         b.idx  = (k < BT) ? IW'($urandom_range(0, 31)) : IW'($urandom_range(0, 31));
         b.last = 1'b0;
         if (k % BT != 0) b.idx = stim[stim.size() - 1].idx;
         stim.push_back(b);
      end
      for (int c = 0; c < 60; c++) begin
         v  = (stim.size() > 0) && ($urandom_range(0, 3) != 0);
         b  = (stim.size() > 0) ? stim[0] : b;
         dr = (c % 3 == 0);
         run_cycle(v, b.data, b.idx, dr, acc);
         if (acc) void'(stim.pop_front());
         n_cmp++;
         if (obs_rdy !== exp_rdy || obs_vld !== exp_vld || obs_done !== exp_done ||
             (exp_vld && (obs_data !== exp_head.data || obs_idx !== exp_head.idx ||
                          obs_last !== exp_head.last)) ||
             (exp_done && obs_done_idx !== exp_done_idx)) begin
            n_fail++;
            $display("FAIL stall_model c=%0d: got rdy=%b vld=%b data=%h done=%b, want %b %b %h %b",
                     c, obs_rdy, obs_vld, obs_data, obs_done, exp_rdy, exp_vld, exp_head.data,
                     exp_done);
         end
         if (prev_vld && !prev_dr) begin
            n_cmp++;
            if (obs_vld !== 1'b1 || obs_data !== prev_data || obs_idx !== prev_idx) begin
               n_fail++;
               $display("FAIL stall_hold c=%0d: got vld=%b data=%h want 1 data=%h", c, obs_vld,
                        obs_data, prev_data);
            end
         end
         n_cmp++;
         if (obs_done !== prev_last_hs) begin
            n_fail++;
            $display("FAIL stall_done_timing c=%0d: got %b want %b", c, obs_done, prev_last_hs);
         end
         if (obs_done === 1'b1) lines++;
         prev_vld     = (obs_vld === 1'b1);
         prev_dr      = obs_dr;
         prev_data    = obs_data;
         prev_idx     = obs_idx;
         prev_last_hs = (obs_vld === 1'b1) && obs_dr && (obs_last === 1'b1);
      end
      n_cmp++;
      if (lines != 2 || stim.size() != 0) begin
         n_fail++; $display("FAIL stall_lines: got %0d lines, %0d unsent, want 2, 0", lines,
                            stim.size());
      end
   endtask

   task automatic test_reset_midline();
      logic acc;
      int   dones = 0;
      for (int c = 0; c < 3; c++) begin
         run_cycle(1'b1, rand_data(), 5'd8, 1'b1, acc);
      end
      // Two beats of idx 8 have now been handed downstream.
      evict_data_vld = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #1;
      n_cmp++;
      if (evict_data_rdy !== 1'b0 || downstream_txdat_vld !== 1'b0 ||
          downstream_txdat_last !== 1'b0 || downstream_txdat_data !== '0 ||
          downstream_txdat_idx !== '0 || adp_done !== 1'b0 || adp_done_idx !== '0) begin
         n_fail++;
         $display("FAIL midreset_outputs: got rdy=%b vld=%b last=%b idx=%0d done=%b/%0d want 0",
                  evict_data_rdy, downstream_txdat_vld, downstream_txdat_last,
                  downstream_txdat_idx, adp_done, adp_done_idx);
      end
      @(posedge clk);
      #1;
      release_reset();
      for (int c = 0; c < 10; c++) begin
         run_cycle(c >= 2 && c < 6, rand_data(), 5'd7, 1'b1, acc);
         if (obs_done === 1'b1 && obs_done_idx === 5'd7) dones++;
         n_cmp++;
         if (obs_rdy !== exp_rdy || obs_vld !== exp_vld || obs_done !== exp_done ||
             (exp_vld && (obs_data !== exp_head.data || obs_idx !== exp_head.idx ||
                          obs_last !== exp_head.last)) ||
             (exp_done && obs_done_idx !== exp_done_idx)) begin
            n_fail++;
            $display("FAIL midreset_model c=%0d: got rdy=%b vld=%b idx=%0d done=%b, want %b %b %0d %b",
                     c, obs_rdy, obs_vld, obs_idx, obs_done, exp_rdy, exp_vld, exp_head.idx,
                     exp_done);
         end
         n_cmp++;
         if (obs_done !== (c == 7)) begin
            n_fail++; $display("FAIL midreset_done c=%0d: got %b want %b", c, obs_done, (c == 7));
         end
      end
      n_cmp++;
      if (dones != 1) begin
         n_fail++; $display("FAIL midreset_line7: got %0d completions want 1", dones);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_interleave();
      test_back_to_back();
      test_stall();
      test_reset_midline();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
